// File: rtl/ycrcb_pkg.sv
// ycrcb_pkg -- shared types and constants for the 4:2:2 YCrCb stream controller.
// Optional BT.656 timing-reference detection is enabled by YCRCB_TRS_DETECT_EN.
package ycrcb_pkg;

    // Position of the current word inside a Cb,Y0,Cr,Y1 quad
    typedef enum logic [1:0] {
        CB,
        Y0,
        CR,
        Y1
    } phase_t;

    // BT.656 preamble tracker: F1 = 3FF seen, F2 = 3FF,000, F3 = 3FF,000,000
    typedef enum logic [1:0] {
        IDLE,
        F1,
        F2,
        F3
    } trs_state_t;

    localparam logic [9:0]  TRS_FF   = 10'h3FF;
    localparam logic [9:0]  TRS_00   = 10'h000;
    localparam int unsigned XY_H_BIT = 6;
    localparam int unsigned XY_V_BIT = 7;

endpackage

// File: rtl/bt656_trs_detect.sv
// bt656_trs_detect -- BT.656 timing-reference (3FF,000,000,XY) detector.
// Only instantiated when YCRCB_TRS_DETECT_EN is defined.
//   active    : the current valid word is active video (not TRS, inside SAV..EAV)
//   sol_pulse : the current active word is the first one after an SAV
//   eav_pulse : the current valid word is the XY word of an EAV (H=1)
module bt656_trs_detect
    import ycrcb_pkg::*;
#(
    parameter int unsigned DW = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    output logic          active,
    output logic          sol_pulse,
    output logic          eav_pulse
);

    trs_state_t state;
    logic       active_q;
    logic       sol_pend;
    logic       is_ff;
    logic       is_00;
    logic       is_trs;

    // Classify the current word; 3FF is reserved, 000 only counts inside a preamble
    always_comb begin
        is_ff  = (din == DW'(TRS_FF));
        is_00  = (din == DW'(TRS_00));
        is_trs = is_ff || (((state == F1) || (state == F2)) && is_00) || (state == F3);
    end

    assign active    = din_valid && active_q && !is_trs;
    assign sol_pulse = active && sol_pend;
    assign eav_pulse = din_valid && (state == F3) && din[XY_H_BIT];

    // Preamble tracking and active-video window
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            active_q <= 1'b0;
            sol_pend <= 1'b0;
        end else if (din_valid) begin
            if (sol_pend && active)
                sol_pend <= 1'b0;
            case (state)
                IDLE: if (is_ff) state <= F1;
                F1: begin
                    if (is_00)      state <= F2;
                    else if (is_ff) state <= F1;
                    else            state <= IDLE;
                end
                F2: begin
                    if (is_00)      state <= F3;
                    else if (is_ff) state <= F1;
                    else            state <= IDLE;
                end
                F3: begin
                    state <= IDLE;
                    if (!din[XY_H_BIT] && !din[XY_V_BIT]) begin
                        active_q <= 1'b1;
                        sol_pend <= 1'b1;
                    end else begin
                        active_q <= 1'b0;
                        sol_pend <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/ycrcb_stream_ctrl.sv
// ycrcb_stream_ctrl -- demultiplexes a Cb,Y0,Cr,Y1 4:2:2 word stream into
// per-pixel (Y,Cr,Cb) for a downstream converter with CONV_LAT latency, and
// tracks pixel valid / start-of-line alongside the converter pipeline.
// Define YCRCB_TRS_DETECT_EN to take line timing from BT.656 TRS codes
// instead of din_sol.
module ycrcb_stream_ctrl
    import ycrcb_pkg::*;
#(
    parameter int unsigned CONV_LAT = 3,
    parameter int unsigned DW       = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] din,
    input  logic          din_valid,
    input  logic          din_sol,
    input  logic          err_clr,
    output logic [DW-1:0] conv_y,
    output logic [DW-1:0] conv_cr,
    output logic [DW-1:0] conv_cb,
    output logic          pix_valid,
    output logic          pix_sol,
    output logic          seq_err
);

    logic          word_act;
    logic          line_start;
    logic          eav_seen;

    phase_t        phase;
    logic [DW-1:0] cb_hold;
    logic [DW-1:0] y0_hold;
    logic [DW-1:0] cr_hold;
    logic          sol_flag;
    logic          emit;
    logic          emit_sol;
    logic          err_set;
    logic [CONV_LAT-1:0] vld_sr;
    logic [CONV_LAT-1:0] sol_sr;

`ifdef YCRCB_TRS_DETECT_EN
    logic unused_din_sol;

    bt656_trs_detect #(
        .DW(DW)
    ) u_trs (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .active    (word_act),
        .sol_pulse (line_start),
        .eav_pulse (eav_seen)
    );

    assign unused_din_sol = din_sol;
`else
    assign word_act   = din_valid;
    assign line_start = din_valid && din_sol;
    assign eav_seen   = 1'b0;
`endif

    // Emit decode: a line start always re-seeds the quad, so it never emits
    always_comb begin
        emit     = word_act && !line_start && ((phase == CR) || (phase == Y1));
        emit_sol = (phase == CR) && sol_flag;
        err_set  = (phase != CB) && (line_start || eav_seen);
    end

    // Phase FSM, sample holds, converter inputs and sticky ordering error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase    <= CB;
            cb_hold  <= '0;
            y0_hold  <= '0;
            cr_hold  <= '0;
            conv_y   <= '0;
            conv_cr  <= '0;
            conv_cb  <= '0;
            sol_flag <= 1'b0;
            seq_err  <= 1'b0;
        end else begin
            if (err_clr) seq_err <= 1'b0;
            if (err_set) seq_err <= 1'b1;

            if (eav_seen) begin
                phase    <= CB;
                sol_flag <= 1'b0;
            end else if (word_act) begin
                // The line-start word is the first Cb of the new line, so it is
                // latched as Cb even when it lands mid-quad; the old quad is lost
                if (line_start) begin
                    cb_hold  <= din;
                    sol_flag <= 1'b1;
                    phase    <= Y0;
                end else begin
                    case (phase)
                        CB: begin
                            cb_hold <= din;
                            phase   <= Y0;
                        end
                        Y0: begin
                            y0_hold <= din;
                            phase   <= CR;
                        end
                        CR: begin
                            cr_hold  <= din;
                            conv_y   <= y0_hold;
                            conv_cr  <= din;
                            conv_cb  <= cb_hold;
                            sol_flag <= 1'b0;
                            phase    <= Y1;
                        end
                        Y1: begin
                            conv_y  <= din;
                            conv_cr <= cr_hold;
                            conv_cb <= cb_hold;
                            phase   <= CB;
                        end
                        default: phase <= CB;
                    endcase
                end
            end
        end
    end

    // Valid/sol delay line matching converter latency; the output flop is the last stage
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_sr    <= '0;
            sol_sr    <= '0;
            pix_valid <= 1'b0;
            pix_sol   <= 1'b0;
        end else begin
            vld_sr[0] <= emit;
            sol_sr[0] <= emit && emit_sol;
            for (int unsigned i = 1; i < CONV_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
                sol_sr[i] <= sol_sr[i-1];
            end
            pix_valid <= vld_sr[CONV_LAT-1];
            pix_sol   <= sol_sr[CONV_LAT-1];
        end
    end

endmodule

// File: tb/tb_ycrcb_stream_ctrl.sv
// tb_ycrcb_stream_ctrl -- scoreboard bench for ycrcb_stream_ctrl.
// Default build exercises the din_sol path; with YCRCB_TRS_DETECT_EN defined
// the BT.656 SAV/EAV path is exercised instead.
module tb_ycrcb_stream_ctrl;

    localparam int LAT = 3;
    localparam int DW  = 10;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] din = '0;
    logic          din_valid = 1'b0;
    logic          din_sol = 1'b0;
    logic          err_clr = 1'b0;
    logic [DW-1:0] conv_y, conv_cr, conv_cb;
    logic          pix_valid, pix_sol, seq_err;

    typedef struct {
        logic [DW-1:0] y;
        logic [DW-1:0] cr;
        logic [DW-1:0] cb;
        logic          sol;
    } pix_t;

    pix_t          exp_q[$];
    pix_t          e;
    int            n_cmp = 0;
    int            n_err = 0;
    logic [DW-1:0] hy[LAT];
    logic [DW-1:0] hcr[LAT];
    logic [DW-1:0] hcb[LAT];

    always #5 clk = ~clk;

    ycrcb_stream_ctrl #(
        .CONV_LAT(LAT),
        .DW(DW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_valid (din_valid),
        .din_sol   (din_sol),
        .err_clr   (err_clr),
        .conv_y    (conv_y),
        .conv_cr   (conv_cr),
        .conv_cb   (conv_cb),
        .pix_valid (pix_valid),
        .pix_sol   (pix_sol),
        .seq_err   (seq_err)
    );

    initial begin
        for (int i = 0; i < LAT; i++) begin
            hy[i] = '0; hcr[i] = '0; hcb[i] = '0;
        end
    end

    // Monitor: on pix_valid, the converter inputs LAT cycles earlier form the pixel
    always @(negedge clk) begin
        if (pix_valid) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_pix: got pix_valid=1 conv=(%0d,%0d,%0d), expected no pixel",
                         hy[LAT-1], hcr[LAT-1], hcb[LAT-1]);
            end else begin
                e = exp_q.pop_front();
                if (hy[LAT-1] !== e.y || hcr[LAT-1] !== e.cr || hcb[LAT-1] !== e.cb || pix_sol !== e.sol) begin
                    n_err++;
                    $display("FAIL pixel: got (y=%0d cr=%0d cb=%0d sol=%0b), expected (y=%0d cr=%0d cb=%0d sol=%0b)",
                             hy[LAT-1], hcr[LAT-1], hcb[LAT-1], pix_sol, e.y, e.cr, e.cb, e.sol);
                end
            end
        end else if (pix_sol !== 1'b0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pix_sol_alone: got pix_sol=%0b without pix_valid, expected 0", pix_sol);
        end
        for (int i = LAT - 1; i > 0; i--) begin
            hy[i] = hy[i-1]; hcr[i] = hcr[i-1]; hcb[i] = hcb[i-1];
        end
        hy[0] = conv_y; hcr[0] = conv_cr; hcb[0] = conv_cb;
    end

    task automatic check(input string name, input int act, input int exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    task automatic push(input int y, input int cr, input int cb, input logic sol);
        pix_t p;
        p.y = DW'(y); p.cr = DW'(cr); p.cb = DW'(cb); p.sol = sol;
        exp_q.push_back(p);
    endtask

    task automatic send(input int w, input logic sol = 1'b0, input logic clr = 1'b0);
        din = DW'(w); din_valid = 1'b1; din_sol = sol; err_clr = clr;
        @(posedge clk); #1;
        din_valid = 1'b0; din_sol = 1'b0; err_clr = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_conv_y", conv_y, 0);
        check("rst_conv_cr", conv_cr, 0);
        check("rst_conv_cb", conv_cb, 0);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_seq_err", seq_err, 0);
        rst = 1'b0;
        idle(2);

`ifdef YCRCB_TRS_DETECT_EN
        // SAV then two quads of active video
        send(10'h3FF); send(10'h000); send(10'h000); send(10'h200);
        send(10); send(20); push(20, 30, 10, 1'b1); send(30); push(40, 30, 10, 1'b0); send(40);
        send(50); send(60); push(60, 70, 50, 1'b0); send(70); push(80, 70, 50, 1'b0); send(80);
        // EAV then blanking words: nothing may be emitted
        send(10'h3FF); send(10'h000); send(10'h000); send(10'h274);
        send(1); send(2); send(3); send(4);
        check("eav_no_err", seq_err, 0);
        idle(10);
`else
        // Back-to-back quad with line start
        send(200, 1'b1); send(300); push(300, 600, 200, 1'b1); send(600); push(400, 600, 200, 1'b0); send(400);
        idle(6);
        // din_valid toggling: same pixel values, stretched spacing
        send(100); idle(1); send(150); idle(1);
        push(150, 700, 100, 1'b0); send(700); idle(1);
        push(250, 700, 100, 1'b0); send(250); idle(1);
        // Extreme sample values pass through unmodified
        send(1023, 1'b1); send(0); push(0, 512, 1023, 1'b1); send(512); push(1, 512, 1023, 1'b0); send(1);
        idle(8);
        check("drain_a", exp_q.size(), 0);

        // Line start after three words of a quad
        check("seq_err_clean", seq_err, 0);
        send(10); send(20); push(20, 30, 10, 1'b0); send(30);
        send(40, 1'b1);
        check("seq_err_set", seq_err, 1);
        send(50); push(50, 60, 40, 1'b1); send(60); push(70, 60, 40, 1'b0); send(70);
        // Clear together with a new error: set wins
        send(5);
        send(6, 1'b1, 1'b1);
        check("seq_err_set_wins", seq_err, 1);
        err_clr = 1'b1; idle(1); err_clr = 1'b0;
        check("seq_err_cleared", seq_err, 0);
        send(7); push(7, 8, 6, 1'b1); send(8); push(9, 8, 6, 1'b0); send(9);
        idle(8);
        check("drain_b", exp_q.size(), 0);

        // Reset one cycle after a Cr emit: that pixel must never appear
        send(11); send(12); send(13);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("midrst_conv_y", conv_y, 0);
        check("midrst_conv_cr", conv_cr, 0);
        check("midrst_conv_cb", conv_cb, 0);
        check("midrst_pix_valid", pix_valid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        idle(8);
        send(3, 1'b1); send(4); push(4, 5, 3, 1'b1); send(5); push(6, 5, 3, 1'b0); send(6);
        idle(8);
`endif
        check("drain_final", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
